// File: rtl/isqrt_arb_pkg.sv
// Shared types for the isqrt sharing arbiter: requester-id width and the tag carried
// alongside each in-flight isqrt operation.
package isqrt_arb_pkg;

    localparam int unsigned MAX_REQ = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the largest supported requester count so the tag type is shared by all builds.
    localparam int unsigned ID_W = id_width(MAX_REQ);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } isqrt_tag_t;

endpackage

// File: rtl/isqrt_arb_tag_pipe.sv
// Fixed-depth shift register of {vld, id} tags that tracks operations inside the isqrt,
// so each result can be matched to the requester that issued it.
module isqrt_arb_tag_pipe
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  isqrt_tag_t tag_in,
    output isqrt_tag_t tag_out
);

    isqrt_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/isqrt_share_arbiter.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters with result routing.
// Define ISQRT_ARB_CHECK_EN to enable the sticky tag/result mismatch flag on err.
module isqrt_share_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ISQRT_LATENCY = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_rdy,
    output logic [N_REQ-1:0]       rsp_vld,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   isqrt_x_vld,
    output logic [WIDTH-1:0]       isqrt_x,
    input  logic                   isqrt_y_vld,
    input  logic [WIDTH-1:0]       isqrt_y,
    output logic                   err
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    winner;
    logic [ID_W:0]      arb_idx;
    logic               found;
    logic [MAX_REQ-1:0] vld_pad;
    logic [WIDTH-1:0]   data_arr [MAX_REQ];
    isqrt_tag_t         tag_in, tail;
    logic               fire;
    logic [N_REQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic [WIDTH-1:0]   rsp_data_q;

    // Pad requests to MAX_REQ so the rotating index never selects outside the vectors.
    assign vld_pad = MAX_REQ'(req_vld);

    for (genvar g = 0; g < MAX_REQ; g++) begin : g_data
        if (g < N_REQ) begin : g_used
            assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
        end else begin : g_unused
            assign data_arr[g] = '0;
        end
    end

    always_comb begin
        found   = 1'b0;
        winner  = '0;
        arb_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            arb_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (arb_idx >= (ID_W+1)'(N_REQ)) begin
                arb_idx = arb_idx - (ID_W+1)'(N_REQ);
            end
            if (!found && vld_pad[arb_idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = arb_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rdy[i] = found && (winner == ID_W'(i));
        end
        isqrt_x_vld = found;
        isqrt_x     = found ? data_arr[winner] : '0;
        ptr_d       = ptr_q;
        if (found) begin
            ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
        tag_in = '{vld: found, id: winner};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    isqrt_arb_tag_pipe #(
        .DEPTH (ISQRT_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tail)
    );

`ifdef ISQRT_ARB_CHECK_EN
    logic err_q;

    // A result without a matching in-flight tag is flagged and not routed anywhere.
    assign fire = isqrt_y_vld && tail.vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (isqrt_y_vld != tail.vld) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign fire = isqrt_y_vld;
    assign err  = 1'b0;
`endif

    always_comb begin
        rsp_vld_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_vld_d[i] = fire && (tail.id == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            if (fire) begin
                rsp_data_q <= isqrt_y;
            end
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Scoreboard bench for isqrt_share_arbiter with a behavioural pipelined isqrt stub.
// With ISQRT_ARB_CHECK_EN defined, a stray isqrt result is injected to exercise err.
module tb_isqrt_share_arbiter;

    localparam int N   = 3;
    localparam int W   = 32;
    localparam int LAT = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_vld = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   rsp_vld;
    logic [W-1:0]   rsp_data;
    logic           isqrt_x_vld;
    logic [W-1:0]   isqrt_x;
    logic           isqrt_y_vld;
    logic [W-1:0]   isqrt_y;
    logic           err;
    logic           inject = 1'b0;

    always #5 clk = ~clk;

    isqrt_share_arbiter #(
        .N_REQ         (N),
        .WIDTH         (W),
        .ISQRT_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .err         (err)
    );

    function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
        longint unsigned r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= longint'(x)) r = t;
        end
        return 32'(r);
    endfunction

    // Behavioural isqrt: fixed latency, fully pipelined, shares the reset.
    logic         sv_q [LAT];
    logic [W-1:0] sd_q [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                sv_q[i] <= 1'b0;
                sd_q[i] <= '0;
            end
        end else begin
            sv_q[0] <= isqrt_x_vld;
            sd_q[0] <= ref_isqrt(isqrt_x);
            for (int i = 1; i < LAT; i++) begin
                sv_q[i] <= sv_q[i-1];
                sd_q[i] <= sd_q[i-1];
            end
        end
    end

    assign isqrt_y_vld = sv_q[LAT-1] | inject;
    assign isqrt_y     = sd_q[LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] res;
        int          cyc;
    } sb_t;

    sb_t         sb [$];
    sb_t         e_q;
    logic [31:0] src [N][$];
    logic [31:0] rlog1 [$];
    bit          acc [N];
    int          gcount [N];
    int          mptr = 0;
    int          mw;
    int          cyc = 0;
    bit          exp_err = 1'b0;

    // Reference arbiter and scoreboard, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            mptr    = 0;
            exp_err = 1'b0;
            for (int i = 0; i < N; i++) acc[i] = 1'b0;
            check_eq("rst_rsp_vld", 64'(rsp_vld), 64'd0);
            check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
            check_eq("rst_err", 64'(err), 64'd0);
        end else begin
            mw = -1;
            for (int j = 0; j < N; j++) begin
                if (mw < 0 && req_vld[(mptr + j) % N]) mw = (mptr + j) % N;
            end
            check_eq("req_rdy", 64'(req_rdy), (mw < 0) ? 64'd0 : (64'd1 << mw));
            check_eq("isqrt_x_vld", 64'(isqrt_x_vld), 64'(mw >= 0));
            if (mw >= 0) begin
                check_eq("isqrt_x", 64'(isqrt_x), 64'(src[mw][0]));
                sb.push_back('{id: mw, res: ref_isqrt(src[mw][0]), cyc: cyc});
                acc[mw] = 1'b1;
                gcount[mw]++;
                mptr = (mw + 1) % N;
            end else begin
                check_eq("isqrt_x_idle", 64'(isqrt_x), 64'd0);
            end
            if (rsp_vld != '0) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(rsp_vld), 64'd0);
                end else begin
                    e_q = sb.pop_front();
                    check_eq("rsp_route", 64'(rsp_vld), 64'd1 << e_q.id);
                    check_eq("rsp_data", 64'(rsp_data), 64'(e_q.res));
                    check_eq("rsp_latency", 64'(cyc - e_q.cyc), 64'(LAT + 1));
                    if (e_q.id == 1) rlog1.push_back(rsp_data);
                end
            end
            if (sb.size() > 0 && (cyc - sb[0].cyc) > LAT + 1) begin
                check_eq("rsp_missing", 64'(cyc - sb[0].cyc), 64'(LAT + 1));
                void'(sb.pop_front());
            end
            check_eq("err", 64'(err), 64'(exp_err));
        end
    end

    // Requesters hold their front operand until the reference arbiter saw it accepted.
    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(src[i].pop_front());
                acc[i] = 1'b0;
            end
            req_vld[i]          = (src[i].size() > 0);
            req_data[i*W +: W]  = (src[i].size() > 0) ? src[i][0] : '0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            apply();
        end
    endtask

    function automatic bit idle();
        bit r;
        r = (sb.size() == 0);
        for (int i = 0; i < N; i++) r = r && (src[i].size() == 0);
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !idle()) begin
            tick(1);
            n++;
        end
        if (n >= budget) check_eq("drain_timeout", 64'(n), 64'd0);
        tick(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            acc[i]    = 1'b0;
            gcount[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Contention straight after reset: req0 then req1.
        src[0].push_back(32'd16);
        src[1].push_back(32'd81);
        tick(1);
        wait_idle(60);

        // Single requester.
        src[0].push_back(32'd49);
        tick(1);
        wait_idle(60);

        // Back-to-back from one requester, including the boundary operands.
        rlog1.delete();
        src[1].push_back(32'd0);
        src[1].push_back(32'd1);
        src[1].push_back(32'd4);
        src[1].push_back(32'hFFFF_FFFF);
        tick(1);
        wait_idle(60);
        check_eq("b2b_count", 64'(rlog1.size()), 64'd4);
        if (rlog1.size() == 4) begin
            check_eq("b2b_0", 64'(rlog1[0]), 64'd0);
            check_eq("b2b_1", 64'(rlog1[1]), 64'd1);
            check_eq("b2b_2", 64'(rlog1[2]), 64'd2);
            check_eq("b2b_3", 64'(rlog1[3]), 64'd65535);
        end

        // Streaming fairness: all valid for 30 cycles.
        for (int i = 0; i < N; i++) begin
            gcount[i] = 0;
            for (int k = 0; k < 10; k++) src[i].push_back($urandom);
        end
        tick(1);
        wait_idle(120);
        for (int i = 0; i < N; i++) check_eq($sformatf("fair_%0d", i), 64'(gcount[i]), 64'd10);

        // Reset with operations in flight.
        src[0].push_back(32'd100);
        src[0].push_back(32'd144);
        src[1].push_back(32'd9);
        src[1].push_back(32'd10);
        src[2].push_back(32'd1000);
        tick(8);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            src[i].delete();
            acc[i] = 1'b0;
        end
        apply();
        tick(2);
        rst_n = 1'b1;
        tick(30);

        // Pointer back at 0: req0 wins over req1.
        src[1].push_back(32'd625);
        src[0].push_back(32'd25);
        tick(1);
        wait_idle(60);

`ifdef ISQRT_ARB_CHECK_EN
        @(posedge clk);
        #1 inject = 1'b1;
        @(posedge clk);
        #1 inject = 1'b0;
        exp_err = 1'b1;
        tick(6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
